gpio_mmio_responder: RTL and testbench

Memory-mapped GPIO peripheral that answers the core's load/store bus requests. It drives gpio_port_out and samples gpio_port_in.
- Input path: synchronizes, debounces and edge-detects gpio_port_in.
- Output path: holds an output register with set/clear aliases.
- Raises a level interrupt on unmasked edges.
- Sits between the core's data-memory decode and the chip pins.

---
 rtl/gpio_pkg.sv | 22 ++
 rtl/gpio_in_debounce.sv | 42 ++++
 rtl/gpio_mmio_responder.sv | 135 +++++++++++++
 tb/tb_gpio_mmio_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared register offsets, handshake state encoding and request bundle for the GPIO responder.
package gpio_pkg;

  localparam logic [4:0] GPIO_DATA_OUT    = 5'h00;
  localparam logic [4:0] GPIO_OUT_SET     = 5'h04;
  localparam logic [4:0] GPIO_OUT_CLR     = 5'h08;
  localparam logic [4:0] GPIO_DATA_IN     = 5'h0C;
  localparam logic [4:0] GPIO_EDGE_STATUS = 5'h10;
  localparam logic [4:0] GPIO_EDGE_MASK   = 5'h14;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } gpio_state_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } gpio_req_t;

endpackage

// File: rtl/gpio_in_debounce.sv
// Per-pin two-flop synchronizer plus run-length debounce; stable follows the pin after DEBOUNCE_CYCLES agreeing samples.
// Latency: DEBOUNCE_CYCLES+2 edges pin-to-stable; no backpressure, samples every cycle.
module gpio_in_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic stable,
  output logic upd
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // upd is the cycle in which stable flips; the top uses it as the edge strobe
  assign upd = (sync2 != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (upd) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/gpio_mmio_responder.sv
// MMIO GPIO block: output register with set/clear aliases, debounced inputs, edge capture and level irq.
// Latency: response one cycle after accept; backpressure: req_ready low in the response cycle (1 req / 2 cycles).
module gpio_mmio_responder
  import gpio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ARM_CYCLES      = DEBOUNCE_CYCLES + 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [4:0]       req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  input  logic [WIDTH-1:0] gpio_port_in,
  output logic [WIDTH-1:0] gpio_port_out,
  output logic             irq
);

  localparam int AW = $clog2(ARM_CYCLES + 1);

  gpio_state_t      state;
  gpio_state_t      state_nxt;
  gpio_req_t        req;
  logic             accept;
  logic [2:0]       sel;
  logic [WIDTH-1:0] wr_dat;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] edge_status;
  logic [WIDTH-1:0] edge_mask;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] din_upd;
  logic [WIDTH-1:0] hw_set;
  logic [WIDTH-1:0] w1c;
  logic [31:0]      rd_dat;
  logic [31:0]      resp_rdata_q;
  logic [AW-1:0]    arm_cnt;
  logic             unused_bits;

  assign req         = {req_we, req_addr, req_wdata};
  assign sel         = req.addr[4:2];
  assign wr_dat      = req.wdata[WIDTH-1:0];
  assign unused_bits = ^{req.addr[1:0], req.wdata};

  for (genvar i = 0; i < WIDTH; i++) begin : g_in
    gpio_in_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk    (clk),
      .rst    (rst),
      .pin    (gpio_port_in[i]),
      .stable (din[i]),
      .upd    (din_upd[i])
    );
  end

  // Edges are ignored until the arm counter drains, hiding the post-reset settle of the input path
  assign hw_set = (arm_cnt == '0) ? din_upd : '0;
  assign w1c    = (accept && req.we && sel == GPIO_EDGE_STATUS[4:2]) ? wr_dat : '0;

  always_comb begin
    rd_dat = '0;
    case (sel)
      GPIO_DATA_OUT[4:2]:    rd_dat = 32'(data_out);
      GPIO_DATA_IN[4:2]:     rd_dat = 32'(din);
      GPIO_EDGE_STATUS[4:2]: rd_dat = 32'(edge_status);
      GPIO_EDGE_MASK[4:2]:   rd_dat = 32'(edge_mask);
      default:               rd_dat = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_nxt  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out     <= '0;
      edge_status  <= '0;
      edge_mask    <= '0;
      irq          <= 1'b0;
      resp_rdata_q <= '0;
      arm_cnt      <= AW'(ARM_CYCLES);
    end else begin
      irq         <= |(edge_status & edge_mask);
      // Hardware set is OR'd in after the clear so a coincident edge survives W1C
      edge_status <= (edge_status & ~w1c) | hw_set;
      if (arm_cnt != '0) begin
        arm_cnt <= arm_cnt - AW'(1);
      end
      if (accept) begin
        resp_rdata_q <= req.we ? '0 : rd_dat;
        if (req.we) begin
          case (sel)
            GPIO_DATA_OUT[4:2]:  data_out  <= wr_dat;
            GPIO_OUT_SET[4:2]:   data_out  <= data_out | wr_dat;
            GPIO_OUT_CLR[4:2]:   data_out  <= data_out & ~wr_dat;
            GPIO_EDGE_MASK[4:2]: edge_mask <= wr_dat;
            default: ;
          endcase
        end
      end
    end
  end

  assign resp_rdata    = resp_rdata_q;
  assign gpio_port_out = data_out;

endmodule

// File: tb/tb_gpio_mmio_responder.sv
// Directed bench for gpio_mmio_responder: register-access vector table plus hand sequences for
// handshake, debounce timing, interrupt/W1C collision and reset during a transaction.
module tb_gpio_mmio_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [7:0]  gpio_port_in;
  logic [7:0]  gpio_port_out;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_out;
  } vec_t;

  vec_t        vecs[18];
  logic [4:0]  hs_addr[4];
  logic [31:0] hs_exp[4];
  logic [31:0] rd;
  logic [7:0]  o;
  logic        iq;

  gpio_mmio_responder dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .gpio_port_in  (gpio_port_in),
    .gpio_port_out (gpio_port_out),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000 expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus transaction; captures rdata, pin outputs and irq in the response cycle.
  task automatic xfer(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic [7:0] out_r, output logic irq_r);
    int n;
    n     = 0;
    rdata = '0;
    out_r = '0;
    irq_r = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    while (!req_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL xfer_timeout: req_ready=0 expected 1");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("resp_valid", 32'(resp_valid), 32'd1);
    rdata = resp_rdata;
    out_r = gpio_port_out;
    irq_r = irq;
    @(posedge clk); #1;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] r;
    logic [7:0]  ov;
    logic        ir;
    xfer(1'b0, addr, 32'h0, r, ov, ir);
    chk(name, r, exp);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'h00, 32'h0000_00A5, 32'h0, 8'hA5};
    vecs[1]  = '{1'b1, 5'h04, 32'h0000_000F, 32'h0, 8'hAF};
    vecs[2]  = '{1'b1, 5'h08, 32'h0000_0081, 32'h0, 8'h2E};
    vecs[3]  = '{1'b0, 5'h00, 32'h0,         32'h2E, 8'h2E};
    vecs[4]  = '{1'b0, 5'h04, 32'h0,         32'h0, 8'h2E};
    vecs[5]  = '{1'b0, 5'h08, 32'h0,         32'h0, 8'h2E};
    vecs[6]  = '{1'b1, 5'h00, 32'hFFFF_FF5A, 32'h0, 8'h5A};
    vecs[7]  = '{1'b0, 5'h03, 32'h0,         32'h5A, 8'h5A};
    vecs[8]  = '{1'b1, 5'h14, 32'h0000_01F0, 32'h0, 8'h5A};
    vecs[9]  = '{1'b0, 5'h14, 32'h0,         32'hF0, 8'h5A};
    vecs[10] = '{1'b1, 5'h14, 32'h0,         32'h0, 8'h5A};
    vecs[11] = '{1'b1, 5'h18, 32'h0000_00FF, 32'h0, 8'h5A};
    vecs[12] = '{1'b0, 5'h18, 32'h0,         32'h0, 8'h5A};
    vecs[13] = '{1'b0, 5'h1C, 32'h0,         32'h0, 8'h5A};
    vecs[14] = '{1'b1, 5'h0C, 32'h0,         32'h0, 8'h5A};
    vecs[15] = '{1'b0, 5'h0C, 32'h0,         32'h3, 8'h5A};
    vecs[16] = '{1'b1, 5'h10, 32'h0000_00FF, 32'h0, 8'h5A};
    vecs[17] = '{1'b0, 5'h10, 32'h0,         32'h0, 8'h5A};
    hs_addr  = '{5'h00, 5'h0C, 5'h14, 5'h00};
    hs_exp   = '{32'h5A, 32'h3, 32'h0, 32'h5A};

    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    gpio_port_in = 8'h03;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 32'(gpio_port_out), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rd_chk("armed_data_in", 5'h0C, 32'h3);
    rd_chk("armed_edge_status", 5'h10, 32'h0);
    chk("armed_irq", 32'(irq), 32'd0);

    // Register map vectors
    for (int i = 0; i < 18; i++) begin
      xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, o, iq);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_out", i), 32'(o), 32'(vecs[i].exp_out));
    end

    // Back-to-back reads with req_valid held high
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_wdata = '0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("hs%0d_ready", k), 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("hs%0d_resp_valid", k), 32'(resp_valid), (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k % 2 == 0) req_addr = hs_addr[k/2];
      else chk($sformatf("hs%0d_rdata", k), resp_rdata, hs_exp[k/2]);
      if (k == 7) req_valid = 1'b0;
      @(posedge clk); #1;
    end
    chk("hs_tail_resp_valid", 32'(resp_valid), 32'd0);
    chk("hs_tail_ready", 32'(req_ready), 32'd1);

    // Glitch of DEBOUNCE_CYCLES-1 synchronized cycles on bit2
    gpio_port_in = 8'h07;
    repeat (3) @(posedge clk);
    #1;
    gpio_port_in = 8'h03;
    repeat (10) @(posedge clk);
    #1;
    rd_chk("glitch_data_in", 5'h0C, 32'h3);
    rd_chk("glitch_edge_status", 5'h10, 32'h0);

    // Clean step on bit2: status at edge 6, irq one edge later
    xfer(1'b1, 5'h14, 32'h4, rd, o, iq);
    chk("mask_irq_idle", 32'(irq), 32'd0);
    gpio_port_in = 8'h07;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      chk($sformatf("step_irq_edge%0d", k), 32'(irq), (k == 7) ? 32'd1 : 32'd0);
    end
    rd_chk("step_data_in", 5'h0C, 32'h7);
    rd_chk("step_edge_status", 5'h10, 32'h4);

    // Mask write with status pending
    xfer(1'b1, 5'h14, 32'h0, rd, o, iq);
    chk("unmask_irq", 32'(irq), 32'd0);
    xfer(1'b1, 5'h14, 32'h4, rd, o, iq);
    chk("remask_irq_at_resp", 32'(iq), 32'd0);
    chk("remask_irq_next", 32'(irq), 32'd1);

    // W1C accepted on the same edge as a new debounced fall of bit2
    gpio_port_in = 8'h03;
    repeat (5) @(posedge clk);
    #1;
    xfer(1'b1, 5'h10, 32'h4, rd, o, iq);
    chk("collide_irq_at_resp", 32'(iq), 32'd1);
    chk("collide_irq_next", 32'(irq), 32'd1);
    rd_chk("collide_edge_status", 5'h10, 32'h4);
    rd_chk("collide_data_in", 5'h0C, 32'h3);

    // Plain W1C
    xfer(1'b1, 5'h10, 32'h4, rd, o, iq);
    chk("w1c_irq_at_resp", 32'(iq), 32'd1);
    chk("w1c_irq_next", 32'(irq), 32'd0);
    rd_chk("w1c_edge_status", 5'h10, 32'h0);

    // Reset on the accept edge of a read
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 5'h00;
    rst       = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 1'b0;
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_out", 32'(gpio_port_out), 32'h0);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    rd_chk("midrst_edge_status", 5'h10, 32'h0);
    rd_chk("midrst_data_in", 5'h0C, 32'h3);
    rd_chk("midrst_data_out", 5'h00, 32'h0);
    rd_chk("midrst_mask", 5'h14, 32'h0);
    chk("midrst_irq", 32'(irq), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
